// File: rtl/bluetooth_tx_arbiter.sv
// Round-robin arbiter that frames one requester's payload as
// sync, source id, payload, checksum and drives it byte by byte
// over the sender's start/data/done handshake, with a per-byte watchdog.
module bluetooth_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned PAYLOAD_LEN = 7,
  parameter logic [7:0]  SYNC_BYTE   = 8'hAA,
  parameter int unsigned TIMEOUT_CYC = 2000000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*PAYLOAD_LEN*8-1:0] req_payload,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             pkt_done,
  output logic                           pkt_err,
  output logic                           busy,
  output logic                           bt_start,
  output logic [7:0]                     bt_data,
  input  logic                           bt_done
);

  localparam int unsigned SW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned FRAME_LEN = PAYLOAD_LEN + 3;
  localparam int unsigned IW        = $clog2(FRAME_LEN);
  localparam int unsigned PW        = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
  localparam int unsigned PLW       = PAYLOAD_LEN * 8;
  localparam int unsigned WW        = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);
  localparam logic [IW-1:0] PAY_LO   = IW'(2);
  localparam logic [IW-1:0] PAY_HI   = IW'(PAYLOAD_LEN + 1);
  // Abort is taken on the cycle the watchdog steps onto TIMEOUT_CYC-1,
  // so pkt_err lands exactly TIMEOUT_CYC cycles after bt_start.
  localparam logic [WW-1:0] WD_HIT   = WW'(TIMEOUT_CYC - 2);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FINISH, ABORT} state_t;

  state_t            state, state_n;
  logic [SW-1:0]     win, win_n;
  logic [SW-1:0]     ptr, ptr_n;
  logic [IW-1:0]     idx, idx_n;
  logic [7:0]        chk, chk_n;
  logic [WW-1:0]     wd, wd_n;
  logic [NUM_REQ-1:0] gnt_n, pkt_done_n;
  logic              pkt_err_n, busy_n, bt_start_n;
  logic [7:0]        bt_data_n;
  logic              buf_load;

  logic [7:0]        pay_buf [PAYLOAD_LEN];
  logic [SW-1:0]     rr_win;
  int unsigned       rr_cand;
  logic [PLW-1:0]    win_payload;
  logic [7:0]        cur_byte;
  logic [SW-1:0]     ptr_adv;

  // Round-robin pick: lowest offset from ptr with req set wins.
  always_comb begin
    rr_win  = ptr;
    rr_cand = 0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      rr_cand = (32'(ptr) + i - 1) % NUM_REQ;
      if (req[SW'(rr_cand)]) rr_win = SW'(rr_cand);
    end
  end

  // Payload slice of the candidate winner and pointer advance past current winner.
  always_comb begin
    win_payload = PLW'(req_payload >> (32'(rr_win) * PLW));
    ptr_adv     = (win == SW'(NUM_REQ - 1)) ? '0 : win + SW'(1);
  end

  // Byte selected by the frame index.
  always_comb begin
    cur_byte = pay_buf[PW'(idx - PAY_LO)];
    if (idx == '0)            cur_byte = SYNC_BYTE;
    else if (idx == IW'(1))   cur_byte = 8'(win);
    else if (idx == LAST_IDX) cur_byte = chk;
  end

  // Payload buffer, captured at grant so later input changes cannot leak in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(PAYLOAD_LEN); i++) pay_buf[i] <= '0;
    end else if (buf_load) begin
      for (int i = 0; i < int'(PAYLOAD_LEN); i++) pay_buf[i] <= win_payload[i*8 +: 8];
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      win      <= '0;
      ptr      <= '0;
      idx      <= '0;
      chk      <= '0;
      wd       <= '0;
      gnt      <= '0;
      pkt_done <= '0;
      pkt_err  <= 1'b0;
      busy     <= 1'b0;
      bt_start <= 1'b0;
      bt_data  <= 8'h00;
    end else begin
      state    <= state_n;
      win      <= win_n;
      ptr      <= ptr_n;
      idx      <= idx_n;
      chk      <= chk_n;
      wd       <= wd_n;
      gnt      <= gnt_n;
      pkt_done <= pkt_done_n;
      pkt_err  <= pkt_err_n;
      busy     <= busy_n;
      bt_start <= bt_start_n;
      bt_data  <= bt_data_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    win_n      = win;
    ptr_n      = ptr;
    idx_n      = idx;
    chk_n      = chk;
    wd_n       = wd;
    gnt_n      = gnt;
    pkt_done_n = '0;
    pkt_err_n  = 1'b0;
    busy_n     = busy;
    bt_start_n = 1'b0;
    bt_data_n  = bt_data;
    buf_load   = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          gnt_n    = NUM_REQ'(1) << rr_win;
          busy_n   = 1'b1;
          win_n    = rr_win;
          idx_n    = '0;
          chk_n    = 8'(rr_win);
          buf_load = 1'b1;
          state_n  = ISSUE;
        end
      end
      ISSUE: begin
        bt_start_n = 1'b1;
        bt_data_n  = cur_byte;
        wd_n       = '0;
        if (idx >= PAY_LO && idx <= PAY_HI) chk_n = chk ^ cur_byte;
        state_n    = WAIT;
      end
      WAIT: begin
        wd_n = wd + WW'(1);
        if (bt_done) begin
          if (idx == LAST_IDX) begin
            state_n = FINISH;
          end else begin
            idx_n   = idx + IW'(1);
            state_n = ISSUE;
          end
        end else if (wd == WD_HIT) begin
          state_n = ABORT;
        end
      end
      FINISH: begin
        pkt_done_n = gnt;
        gnt_n      = '0;
        busy_n     = 1'b0;
        ptr_n      = ptr_adv;
        state_n    = IDLE;
      end
      ABORT: begin
        pkt_err_n = 1'b1;
        gnt_n     = '0;
        busy_n    = 1'b0;
        ptr_n     = ptr_adv;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bluetooth_tx_arbiter.sv
// Scoreboard bench for bluetooth_tx_arbiter: a frame-level model pushes
// expected bytes and completion events; a monitor pops and compares.
module tb_bluetooth_tx_arbiter;

  localparam int unsigned NR   = 2;
  localparam int unsigned PL   = 7;
  localparam int unsigned FL   = PL + 3;
  localparam int unsigned TO   = 50;
  localparam logic [7:0]  SYNC = 8'hAA;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NR-1:0]        req = '0;
  logic [NR*PL*8-1:0]   req_payload = '0;
  logic [NR-1:0]        gnt, pkt_done;
  logic                 pkt_err, busy, bt_start;
  logic [7:0]           bt_data;
  logic                 bt_done = 1'b0;

  bluetooth_tx_arbiter #(
    .NUM_REQ(NR), .PAYLOAD_LEN(PL), .SYNC_BYTE(SYNC), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_payload(req_payload),
    .gnt(gnt), .pkt_done(pkt_done), .pkt_err(pkt_err), .busy(busy),
    .bt_start(bt_start), .bt_data(bt_data), .bt_done(bt_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] data; logic [NR-1:0] gnt;} byte_t;
  typedef struct packed {logic [NR-1:0] done; logic err;} evt_t;

  byte_t      exp_byte_q[$];
  evt_t       exp_evt_q[$];
  int         chk_cnt = 0;
  int         pass_cnt = 0;
  longint     cyc = 0;
  logic [7:0] pl [NR][PL];
  int         ptr_m = 0;

  // sender model configuration (written only by the stimulus process)
  int base_dly = 3;
  bit rand_dly = 1'b0;
  int withhold_at = 0;
  int special_byte = 0;
  int special_dly = 0;
  bit hold_idle_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint want);
    chk_cnt++;
    if (act == want) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, want);
  endtask

  task automatic pack_payload();
    for (int i = 0; i < int'(NR); i++)
      for (int j = 0; j < int'(PL); j++)
        req_payload[(i*PL+j)*8 +: 8] = pl[i][j];
  endtask

  task automatic rand_payload();
    for (int i = 0; i < int'(NR); i++)
      for (int j = 0; j < int'(PL); j++)
        pl[i][j] = 8'($urandom);
    pack_payload();
  endtask

  // Frame-level model: choose the winner, build its frame, queue expectations.
  // trunc != 0 means the frame is aborted after that many bytes were started.
  task automatic push_frame(input logic [NR-1:0] mask, input int trunc);
    int w;
    logic [7:0] fr [FL];
    logic [NR-1:0] oh;
    evt_t e;
    byte_t b;
    int n;
    w = -1;
    for (int i = 0; i < int'(NR); i++)
      if (w < 0 && mask[(ptr_m + i) % NR]) w = (ptr_m + i) % NR;
    oh = '0;
    oh[w] = 1'b1;
    fr[0] = SYNC;
    fr[1] = 8'(w);
    fr[FL-1] = 8'(w);
    for (int j = 0; j < int'(PL); j++) begin
      fr[j+2] = pl[w][j];
      fr[FL-1] = fr[FL-1] ^ pl[w][j];
    end
    n = (trunc != 0) ? trunc : int'(FL);
    for (int k = 0; k < n; k++) begin
      b.data = fr[k];
      b.gnt  = oh;
      exp_byte_q.push_back(b);
    end
    e.done = (trunc != 0) ? '0 : oh;
    e.err  = (trunc != 0);
    exp_evt_q.push_back(e);
    ptr_m = (w + 1) % NR;
  endtask

  // Hold req for nfr frames, drop it (optionally scrambling payloads) once
  // drop_at bytes of the last frame have gone out, then wait for completion.
  task automatic run_frames(input logic [NR-1:0] mask, input int nfr, input int trunc,
                            input int drop_at, input bit scramble);
    int last_len;
    int t;
    pack_payload();
    for (int k = 0; k < nfr; k++) push_frame(mask, (k == nfr-1) ? trunc : 0);
    last_len = (trunc != 0) ? trunc : int'(FL);
    @(negedge clk);
    req = mask;
    t = 0;
    while (exp_byte_q.size() > last_len - drop_at && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check("drop_point_timeout", longint'(t >= 4000), 0);
    req = '0;
    if (scramble) rand_payload();
    t = 0;
    while (exp_evt_q.size() != 0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check("frame_complete_pending", exp_evt_q.size(), 0);
    check("bytes_pending", exp_byte_q.size(), 0);
    exp_evt_q.delete();
    exp_byte_q.delete();
    repeat (2) @(negedge clk);
    check("busy_after_frame", busy, 0);
    check("gnt_after_frame", gnt, 0);
  endtask

  // Byte sender model: answers each bt_start with a bt_done pulse.
  int byte_no = 0;
  int rsp_d = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!busy) begin
        byte_no = 0;
        bt_done = hold_idle_done;
      end else begin
        bt_done = 1'b0;
        if (bt_start) begin
          byte_no++;
          if (byte_no != withhold_at) begin
            if (byte_no == special_byte) rsp_d = special_dly;
            else if (rand_dly)           rsp_d = int'($urandom_range(0, 4));
            else                         rsp_d = base_dly;
            repeat (rsp_d) @(negedge clk);
            bt_done = 1'b1;
            @(negedge clk);
            bt_done = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a byte or an event.
  byte_t  mb;
  evt_t   me;
  longint last_start = 0;
  logic [7:0] last_data = 8'h00;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        if (bt_start) begin
          last_start = cyc;
          last_data  = bt_data;
          if (exp_byte_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_bt_start: got byte %02h, expected no transfer", bt_data);
          end else begin
            mb = exp_byte_q.pop_front();
            check("bt_data", bt_data, mb.data);
            check("gnt_in_frame", gnt, mb.gnt);
          end
        end
        if (bt_done && busy) check("bt_data_held", bt_data, last_data);
        if (pkt_done != '0 || pkt_err) begin
          if (exp_evt_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_event: got pkt_done=%0h pkt_err=%0b, expected none",
                     pkt_done, pkt_err);
          end else begin
            me = exp_evt_q.pop_front();
            check("pkt_done", pkt_done, me.done);
            check("pkt_err", pkt_err, me.err);
            check("gnt_at_end", gnt, 0);
            check("busy_at_end", busy, 0);
            if (me.err) check("abort_latency", cyc - last_start, TO);
          end
        end
      end
    end
  end

  // Stimulus sequence.
  initial begin
    logic flag;
    logic [NR-1:0] m;
    int t;

    #1 rst = 1'b0;
    #2;
    check("rst_gnt", gnt, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_pkt_err", pkt_err, 0);
    check("rst_busy", busy, 0);
    check("rst_bt_start", bt_start, 0);
    check("rst_bt_data", bt_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // bt_done held high while idle must be ignored
    hold_idle_done = 1'b1;
    flag = 1'b0;
    repeat (10) begin
      @(negedge clk);
      #1 flag = flag | busy | bt_start | (|gnt) | pkt_err | (|pkt_done);
    end
    check("idle_bt_done_ignored", flag, 0);
    hold_idle_done = 1'b0;
    @(negedge clk);

    // single frame from source 0, payload 01..07
    for (int j = 0; j < int'(PL); j++) begin
      pl[0][j] = 8'(j + 1);
      pl[1][j] = 8'h00;
    end
    run_frames(2'b01, 1, 0, 1, 1'b0);

    // source 1 checksum frame
    for (int j = 0; j < int'(PL); j++) pl[1][j] = 8'((j + 1) * 16);
    run_frames(2'b10, 1, 0, 1, 1'b0);

    // round-robin with both sources held
    rand_payload();
    run_frames(2'b11, 3, 0, 1, 1'b0);

    // watchdog: third byte never acknowledged, then the other source is served
    rand_payload();
    withhold_at = 3;
    run_frames(2'b11, 1, 3, 1, 1'b0);
    withhold_at = 0;
    run_frames(2'b11, 1, 0, 1, 1'b0);

    // done on the last permitted cycle is accepted
    rand_payload();
    special_byte = 5;
    special_dly  = TO - 2;
    run_frames(2'b01, 1, 0, 1, 1'b0);
    // one cycle later the byte is aborted
    special_dly  = TO - 1;
    run_frames(2'b10, 1, 5, 1, 1'b0);
    special_byte = 0;

    // payload change and req drop during byte 4
    rand_payload();
    run_frames(2'b01, 1, 0, 4, 1'b1);

    // asynchronous reset during WAIT drops the frame silently
    base_dly = 20;
    rand_payload();
    push_frame(2'b01, 0);
    @(negedge clk);
    req = 2'b01;
    t = 0;
    while (exp_byte_q.size() > int'(FL) - 2 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("reset_setup_timeout", longint'(t >= 2000), 0);
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_gnt", gnt, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_bt_start", bt_start, 0);
    req = '0;
    exp_byte_q.delete();
    exp_evt_q.delete();
    ptr_m = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    base_dly = 3;
    run_frames(2'b11, 1, 0, 1, 1'b0);

    // randomized frames
    rand_dly = 1'b1;
    for (int r = 0; r < 20; r++) begin
      m = NR'($urandom_range(1, (1 << NR) - 1));
      rand_payload();
      run_frames(m, int'($urandom_range(1, 2)), 0, int'($urandom_range(1, FL)),
                 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed",
             pass_cnt, chk_cnt);
    $fatal(1);
  end

endmodule
